// File: rtl/hybrid_emergency_request_conditioner.sv
// rtl/hybrid_emergency_request_conditioner.sv - siren request synchronizer, debouncer and arbitration FSM
//
// Purpose: turns two asynchronous siren detectors into clean, mutually exclusive
// emergency levels for the traffic signal FSM. Each channel is synchronized,
// debounced, and edge-detected. A four-state arbiter then holds the accepted
// request for HOLD_CYCLES, followed by a COOLDOWN_CYCLES quiet period.
//
// Ports:
//   clk             - system clock, all state changes on the rising edge
//   reset           - synchronous, active-low reset
//   siren_left_raw  - asynchronous left-approach siren detector, active high
//   siren_right_raw - asynchronous right-approach siren detector, active high
//   emergency_left  - registered left emergency level
//   emergency_right - registered right emergency level
//   dropped         - one-cycle pulse when a qualified request is discarded
//   accept_count    - saturating count of accepted requests

module hybrid_emergency_request_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned HOLD_CYCLES     = 30,
  parameter int unsigned COOLDOWN_CYCLES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       siren_left_raw,
  input  logic       siren_right_raw,
  output logic       emergency_left,
  output logic       emergency_right,
  output logic       dropped,
  output logic [7:0] accept_count
);

  localparam logic [15:0] DEB_LIM  = 16'(DEBOUNCE_CYCLES);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYCLES);
  localparam logic [15:0] COOL_LD  = 16'(COOLDOWN_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LEFT_ACT  = 2'd1,
    ST_RIGHT_ACT = 2'd2,
    ST_COOLDOWN  = 2'd3
  } state_t;

  // Channel index 0 is left, index 1 is right throughout.
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       filt_q, filt_d;
  logic [1:0]       filt_dly_q, filt_dly_d;
  logic [1:0][15:0] deb_cnt_q, deb_cnt_d;

  state_t           state_q, state_d;
  logic [15:0]      hold_q, hold_d;
  logic [15:0]      cool_q, cool_d;
  logic             em_left_q, em_left_d;
  logic             em_right_q, em_right_d;
  logic             dropped_q, dropped_d;
  logic [7:0]       accept_q, accept_d;

  logic             req_left;
  logic             req_right;
  logic             accept_inc;

  // Two-flop synchronizer; sync2 is the sampled value fed to the debouncer.
  always_comb begin
    sync1_d    = {siren_right_raw, siren_left_raw};
    sync2_d    = sync1_q;
    filt_dly_d = filt_q;
  end

  // Debounce: count consecutive disagreements between the sample and the
  // filtered level; flip the level on the edge the count would hit the limit.
  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (sync2_q[ch] != filt_q[ch]) begin
        if (deb_cnt_q[ch] + 16'd1 == DEB_LIM) begin
          filt_d[ch] = ~filt_q[ch];
        end else begin
          deb_cnt_d[ch] = deb_cnt_q[ch] + 16'd1;
        end
      end
    end
  end

  // Only a fresh 0->1 of the filtered level is a request, so a level that is
  // still high when the arbiter returns to idle does not retrigger.
  assign req_left  = filt_q[0] & ~filt_dly_q[0];
  assign req_right = filt_q[1] & ~filt_dly_q[1];

  // Arbiter next-state logic.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cool_d     = cool_q;
    dropped_d  = 1'b0;
    accept_inc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_right) begin
          state_d    = ST_RIGHT_ACT;
          hold_d     = HOLD_LD;
          accept_inc = 1'b1;
          dropped_d  = req_left;
        end else if (req_left) begin
          state_d    = ST_LEFT_ACT;
          hold_d     = HOLD_LD;
          accept_inc = 1'b1;
        end
      end

      ST_LEFT_ACT: begin
        dropped_d = req_left;
        if (req_right) begin
          // Right preempts left; the hold restarts for the right request.
          state_d    = ST_RIGHT_ACT;
          hold_d     = HOLD_LD;
          accept_inc = 1'b1;
        end else if (hold_q == 16'd1) begin
          state_d = ST_COOLDOWN;
          hold_d  = '0;
          cool_d  = COOL_LD;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end

      ST_RIGHT_ACT: begin
        dropped_d = req_left | req_right;
        if (hold_q == 16'd1) begin
          state_d = ST_COOLDOWN;
          hold_d  = '0;
          cool_d  = COOL_LD;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end

      ST_COOLDOWN: begin
        dropped_d = req_left | req_right;
        if (cool_q == 16'd1) begin
          state_d = ST_IDLE;
          cool_d  = '0;
        end else begin
          cool_d = cool_q - 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
        cool_d  = '0;
      end
    endcase
  end

  // Outputs are a registered decode of the current state, so left and right
  // switch on the same edge during preemption and can never overlap.
  always_comb begin
    em_left_d  = (state_q == ST_LEFT_ACT);
    em_right_d = (state_q == ST_RIGHT_ACT);
    accept_d   = accept_q;
    if (accept_inc && (accept_q != 8'hFF)) begin
      accept_d = accept_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      deb_cnt_q  <= '0;
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      cool_q     <= '0;
      em_left_q  <= 1'b0;
      em_right_q <= 1'b0;
      dropped_q  <= 1'b0;
      accept_q   <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_dly_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      cool_q     <= cool_d;
      em_left_q  <= em_left_d;
      em_right_q <= em_right_d;
      dropped_q  <= dropped_d;
      accept_q   <= accept_d;
    end
  end

  assign emergency_left  = em_left_q;
  assign emergency_right = em_right_q;
  assign dropped         = dropped_q;
  assign accept_count    = accept_q;

endmodule

// File: tb/tb_hybrid_emergency_request_conditioner.sv
// tb/tb_hybrid_emergency_request_conditioner.sv - self-checking bench with behavioural reference model

module tb_hybrid_emergency_request_conditioner;

  localparam int DEB  = 3;
  localparam int HOLD = 30;
  localparam int COOL = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       siren_left_raw = 1'b0;
  logic       siren_right_raw = 1'b0;
  logic       emergency_left;
  logic       emergency_right;
  logic       dropped;
  logic [7:0] accept_count;

  int n_checks = 0;
  int n_errors = 0;

  hybrid_emergency_request_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .COOLDOWN_CYCLES(COOL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .siren_left_raw(siren_left_raw),
    .siren_right_raw(siren_right_raw),
    .emergency_left(emergency_left),
    .emergency_right(emergency_right),
    .dropped(dropped),
    .accept_count(accept_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: each channel is a delay line feeding a disagreement
  // run-length filter; the arbiter is a mode plus "cycles left in mode".
  bit m_line[2][2];     // [ch][0] = first sync stage, [ch][1] = sampled value
  bit m_f[2];
  bit m_fprev[2];
  int m_run[2];
  int m_mode;           // 0 idle, 1 left, 2 right, 3 cooldown
  int m_left;
  bit m_out_l, m_out_r, m_drop;
  int m_acc;

  task automatic m_enter(input int mode);
    m_mode = mode;
    m_left = HOLD;
    m_acc  = (m_acc < 255) ? m_acc + 1 : 255;
  endtask

  task automatic model_step(input bit rst_n, input bit rl, input bit rr);
    bit rq[2];
    bit raw[2];
    raw[0] = rl;
    raw[1] = rr;
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_line[c][0] = 0; m_line[c][1] = 0;
        m_f[c] = 0; m_fprev[c] = 0; m_run[c] = 0;
      end
      m_mode = 0; m_left = 0;
      m_out_l = 0; m_out_r = 0; m_drop = 0; m_acc = 0;
      return;
    end
    for (int c = 0; c < 2; c++) rq[c] = m_f[c] && !m_fprev[c];
    m_out_l = (m_mode == 1);
    m_out_r = (m_mode == 2);
    m_drop  = 0;
    if (m_mode == 0) begin
      if (rq[1]) begin m_enter(2); m_drop = rq[0]; end
      else if (rq[0]) m_enter(1);
    end else if (m_mode == 1 && rq[1]) begin
      m_enter(2);
      m_drop = rq[0];
    end else begin
      m_drop = rq[0] || rq[1];
      m_left--;
      if (m_left == 0) begin
        if (m_mode == 3) m_mode = 0;
        else begin m_mode = 3; m_left = COOL; end
      end
    end
    for (int c = 0; c < 2; c++) begin
      m_fprev[c] = m_f[c];
      if (m_line[c][1] != m_f[c]) begin
        m_run[c]++;
        if (m_run[c] == DEB) begin
          m_f[c] = !m_f[c];
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      m_line[c][1] = m_line[c][0];
      m_line[c][0] = raw[c];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(reset, siren_left_raw, siren_right_raw);
    #1;
    check_eq("em_left", emergency_left, m_out_l);
    check_eq("em_right", emergency_right, m_out_r);
    check_eq("dropped", dropped, m_drop);
    check_eq("accept_count", accept_count, m_acc);
    check_eq("no_overlap", emergency_left & emergency_right, 0);
  endtask

  task automatic do_reset();
    siren_left_raw  = 0;
    siren_right_raw = 0;
    reset = 0;
    tick();
    reset = 1;
  endtask

  initial begin
    int n, m, drops, lhigh, runl, runr;

    // Reset state
    do_reset();
    check_eq("rst_left", emergency_left, 0);
    check_eq("rst_right", emergency_right, 0);
    check_eq("rst_dropped", dropped, 0);
    check_eq("rst_acc", accept_count, 0);
    for (int k = 0; k < 5; k++) tick();

    // Left request: latency, hold length, count
    do_reset();
    siren_left_raw = 1;
    n = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (emergency_left) begin n = k; break; end
    end
    check_eq("lat_left", n, DEB + 3);
    m = 1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!emergency_left) break;
      m++;
    end
    check_eq("hold_left", m, HOLD);
    check_eq("acc_left", accept_count, 1);
    for (int k = 0; k < 20; k++) tick();
    check_eq("no_retrigger", accept_count, 1);
    siren_left_raw = 0;
    for (int k = 0; k < 10; k++) tick();

    // Glitch on right shorter than the debounce window
    do_reset();
    drops = 0;
    siren_right_raw = 1;
    tick(); tick();
    siren_right_raw = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      drops += dropped;
      check_eq("glitch_right", emergency_right, 0);
    end
    check_eq("glitch_drops", drops, 0);
    check_eq("glitch_acc", accept_count, 0);

    // Preemption: right arrives 10 cycles into the left hold
    do_reset();
    siren_left_raw = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (emergency_left) break;
    end
    for (int k = 0; k < 10; k++) tick();
    siren_right_raw = 1;
    m = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      m += emergency_right;
    end
    check_eq("preempt_hold", m, HOLD);
    check_eq("preempt_acc", accept_count, 2);
    siren_left_raw = 0;
    siren_right_raw = 0;
    for (int k = 0; k < 10; k++) tick();

    // Simultaneous left and right
    do_reset();
    siren_left_raw = 1;
    siren_right_raw = 1;
    drops = 0;
    lhigh = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      drops += dropped;
      lhigh += emergency_left;
    end
    check_eq("simul_drops", drops, 1);
    check_eq("simul_left", lhigh, 0);
    check_eq("simul_acc", accept_count, 1);
    siren_left_raw = 0;
    siren_right_raw = 0;
    for (int k = 0; k < 10; k++) tick();

    // Reset in the middle of a right hold
    do_reset();
    siren_right_raw = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (emergency_right) break;
    end
    for (int k = 0; k < 14; k++) tick();
    reset = 0;
    tick();
    check_eq("midrst_left", emergency_left, 0);
    check_eq("midrst_right", emergency_right, 0);
    check_eq("midrst_acc", accept_count, 0);
    reset = 1;
    n = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (emergency_right) begin n = k; break; end
    end
    check_eq("midrst_lat", n, DEB + 3);
    siren_right_raw = 0;
    for (int k = 0; k < 50; k++) tick();

    // Randomized traffic with occasional resets early on
    do_reset();
    runl = 0;
    runr = 0;
    for (int cyc = 0; cyc < 24000; cyc++) begin
      if (runl == 0) begin
        siren_left_raw = ~siren_left_raw;
        runl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 60);
      end
      if (runr == 0) begin
        siren_right_raw = ~siren_right_raw;
        runr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 60);
      end
      runl--;
      runr--;
      reset = !(cyc < 4000 && $urandom_range(0, 499) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hybrid_emergency_request_conditioner.md
HYBRID_EMERGENCY_REQUEST_CONDITIONER -- requirements
Module: hybrid_emergency_request_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 3: consecutive synchronized samples required to change a filtered sensor level (legal range 1..65535).
REQ-002 Parameter HOLD_CYCLES, default 30: cycles an accepted emergency output stays high (legal range 1..65535).
REQ-003 Parameter COOLDOWN_CYCLES, default 5: cycles after a hold during which all new requests are discarded (legal range 1..65535).
REQ-004 clk  input  1  system clock, 1 Hz in the traffic system; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 siren_left_raw  input  1  asynchronous left-approach siren detector, active high.
REQ-007 siren_right_raw  input  1  asynchronous right-approach siren detector, active high.
REQ-008 emergency_left  output  1  registered level that drives emergency_left of hybrid_traffic_signal_control_fsm.
REQ-009 emergency_right  output  1  registered level that drives emergency_right of hybrid_traffic_signal_control_fsm.
REQ-010 dropped  output  1  one-cycle pulse when a qualified request is discarded.
REQ-011 accept_count  output  8  saturating count of accepted requests.

Function
REQ-012 Each raw input SHALL pass through a two-flop synchronizer; the second flop is the sampled value s.
REQ-013 Debounce: per channel, a 16-bit counter SHALL increment on each edge where s differs from the filtered level f, clear to 0 on any edge where s equals f, and toggle f (counter cleared) on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-014 A qualified request SHALL be a 0->1 transition of f; it is detected one cycle later via a registered copy of f.
REQ-015 The FSM SHALL have exactly four states: IDLE, LEFT_ACT, RIGHT_ACT, COOLDOWN; outputs are Moore and registered.
REQ-016 IDLE: a right request goes to RIGHT_ACT; otherwise a left request goes to LEFT_ACT; simultaneous left and right requests go to RIGHT_ACT, and dropped pulses for the discarded left.
REQ-017 LEFT_ACT: emergency_left=1 and emergency_right=0; a right request preempts to RIGHT_ACT and reloads the hold counter; a left request is discarded with dropped=1.
REQ-018 RIGHT_ACT: emergency_right=1 and emergency_left=0; any request is discarded with dropped=1; right overrides left because the downstream FSM stops both roads.
REQ-019 The hold counter SHALL load HOLD_CYCLES on state entry and decrement each cycle; the state exits to COOLDOWN on the edge where the count is 1, so the output is high for exactly HOLD_CYCLES cycles (a preempted left is truncated).
REQ-020 COOLDOWN: both outputs 0; any request is discarded with dropped=1; the state returns to IDLE after exactly COOLDOWN_CYCLES cycles.
REQ-021 emergency_left and emergency_right SHALL never be high in the same cycle.
REQ-022 A filtered level still high when the FSM returns to IDLE SHALL NOT retrigger; only a new 0->1 transition of f counts as a request.
REQ-023 accept_count SHALL increment on each transition into LEFT_ACT or RIGHT_ACT, preemption included, and saturate at 255.
REQ-024 Latency: a raw rising edge held stable and sampled at edge 0 SHALL produce an output high after edge DEBOUNCE_CYCLES+3 when the FSM is in IDLE.
REQ-025 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change in f and no dropped pulse.

Reset
REQ-026 With reset=0 at an edge: synchronizers, f, edge registers and debounce counters SHALL clear to 0.
REQ-027 Also with reset=0 at an edge: the FSM SHALL go to IDLE, the hold and cooldown counters clear, emergency_left=0, emergency_right=0, dropped=0 and accept_count=0.
REQ-028 Reset asserted mid-hold or mid-cooldown SHALL abort it immediately; after reset deasserts, a raw input already high SHALL be treated as a new request after full debounce.

Verification
REQ-029 Left request: reset released, siren_left_raw=1 held 40 cycles -> emergency_left rises 6 edges after the first sample, stays high 30 cycles, then 5 cooldown cycles, and accept_count=1.
REQ-030 Glitch: siren_right_raw high for 2 cycles -> no output, dropped=0, accept_count=0.
REQ-031 Preemption: left accepted, right request 10 cycles into the hold -> emergency_left falls on the same edge emergency_right rises, right held 30 cycles, accept_count=2, outputs never overlap.
REQ-032 Simultaneous: both raw inputs rise on the same edge -> RIGHT_ACT only, dropped pulses once, and accept_count=1.
REQ-033 Cooldown discard: a new left request qualifying during COOLDOWN -> dropped=1 for one cycle, the FSM returns to IDLE, and no retrigger while siren_left_raw stays high.
REQ-034 Reset mid-hold: reset=0 for 1 cycle at hold cycle 15 -> both outputs 0 and accept_count=0 on the next edge; with siren_right_raw held at 1, emergency_right rises 6 edges after reset deasserts.
